// File: rtl/serial_rx_if.sv
// rtl/serial_rx_if.sv - serial receiver line input and parallel word output bundle
//
// Purpose: groups the serial line and the receiver's word/strobe outputs.
// Ports (signals):
//   rxd        serial line into the receiver, idle high
//   data_out   last good received word
//   valid      one-cycle strobe, data_out just updated
//   frame_err  one-cycle strobe, stop bit sampled low
//   par_err    one-cycle strobe, parity mismatch
//   busy       receiver is inside a frame
// Modports: master = receiver side, slave = line driver / word consumer side.

interface serial_rx_if #(
    parameter int DATA_W = 8
);
    logic              rxd;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              frame_err;
    logic              par_err;
    logic              busy;

    modport master (
        input  rxd,
        output data_out,
        output valid,
        output frame_err,
        output par_err,
        output busy
    );

    modport slave (
        output rxd,
        input  data_out,
        input  valid,
        input  frame_err,
        input  par_err,
        input  busy
    );
endinterface

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - oversampling asynchronous-format serial frame receiver
//
// Purpose: synchronizes an idle-high serial line, finds the start bit, samples
// each bit mid-cell, checks the stop bit (and even parity when built with
// SERIAL_RX_PARITY_EN defined) and presents each good word with a one-cycle
// valid strobe. No back-pressure.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   serial_rx_if.master: rxd in; data_out, valid, frame_err, par_err,
//         busy out
// Build option: SERIAL_RX_PARITY_EN adds the even-parity bit and par_err.

module serial_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    serial_rx_if.master  bus
);

    localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // Cycle counter value on the edge that lands mid-start-bit, and at the
    // end of every full bit cell after that.
    localparam logic [CYC_W-1:0] CYC_MID  = CYC_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef SERIAL_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              rxd_s;
`ifdef SERIAL_RX_PARITY_EN
    logic              perr_q, perr_d;
    logic              ppend_q, ppend_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            perr_q  <= 1'b0;
            ppend_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef SERIAL_RX_PARITY_EN
            perr_q  <= perr_d;
            ppend_q <= ppend_d;
`endif
        end
    end

    always_comb begin
        sync1_d = bus.rxd;
        sync2_d = sync1_q;
        rxd_s   = sync2_q;

        state_d = state_q;
        cyc_d   = cyc_q + CYC_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        perr_d  = 1'b0;
        ppend_d = ppend_q;
`endif

        unique case (state_q)
            IDLE: begin
                cyc_d = '0;
                if (!rxd_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (cyc_q == CYC_MID) begin
                    cyc_d = '0;
                    bit_d = '0;
                    // A line back high mid-start-bit was only a glitch.
                    state_d = rxd_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    // LSB arrives first, so shift in from the top.
                    shift_d = shift_q >> 1;
                    shift_d[DATA_W-1] = rxd_s;
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_q == BIT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end

`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    ppend_d = ^{shift_q, rxd_s};
                    state_d = STOP;
                end
            end
`endif

            STOP: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (rxd_s) begin
                        state_d = IDLE;
`ifdef SERIAL_RX_PARITY_EN
                        if (ppend_q) begin
                            perr_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
`else
                        data_d  = shift_q;
                        valid_d = 1'b1;
`endif
                    end else begin
                        // Framing error outranks any parity error.
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end

            BREAK: begin
                // Hold off until the line idles so a stuck-low line is not
                // mistaken for a fresh start bit.
                cyc_d = '0;
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cyc_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.data_out  = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
`ifdef SERIAL_RX_PARITY_EN
    assign bus.par_err   = perr_q;
`else
    assign bus.par_err   = 1'b0;
`endif
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - self-checking bench for serial_rx

module tb_serial_rx;

    localparam int C = 4;
    localparam int W = 8;
`ifdef SERIAL_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // Drive edge k -> 2 sync flops -> e0 = k+3; stop sampled C/2 + (W+1+P)*C
    // edges later; the strobe is seen in the cycle after that edge.
    localparam int LAT = 3 + C / 2 + (W + 1 + P) * C;
    localparam int FRAME = (W + 2 + P) * C;

    localparam int EV_VALID = 1;
    localparam int EV_FERR  = 2;
    localparam int EV_PERR  = 3;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] data;
    } ev_t;

    logic clk;
    logic rst;
    int   cycle;
    int   n_checks;
    int   n_errors;

    ev_t        got_q[$];
    ev_t        exp_q[$];
    logic [7:0] last_good;

    serial_rx_if #(.DATA_W(W)) bus ();

    serial_rx #(.DATA_W(W), .CLKS_PER_BIT(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.valid)     got_q.push_back('{EV_VALID, cycle, bus.data_out});
            if (bus.frame_err) got_q.push_back('{EV_FERR,  cycle, bus.data_out});
            if (bus.par_err)   got_q.push_back('{EV_PERR,  cycle, bus.data_out});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        bus.rxd = b;
        tick(C);
    endtask

    // Reference model: outcome of a frame follows from its stop bit and
    // whether the transmitted parity was corrupted.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic pflip);
        int k;
        k = cycle;
        if (!stop) begin
            exp_q.push_back('{EV_FERR, k + LAT, last_good});
        end else if (P == 1 && pflip) begin
            exp_q.push_back('{EV_PERR, k + LAT, last_good});
        end else begin
            exp_q.push_back('{EV_VALID, k + LAT, data});
            last_good = data;
        end
        drive_bit(1'b0);
        for (int i = 0; i < W; i++) drive_bit(data[i]);
        if (P == 1) drive_bit((^data) ^ pflip);
        drive_bit(stop);
    endtask

    task automatic check_events(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_kind"}, got_q[i].kind, exp_q[i].kind);
            check({tag, "_cycle"}, got_q[i].cyc, exp_q[i].cyc);
            check({tag, "_data"}, {24'h0, got_q[i].data}, {24'h0, exp_q[i].data});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       st;
        logic       pf;
        n_checks  = 0;
        n_errors  = 0;
        last_good = 8'h00;
        rst       = 1'b0;
        bus.rxd   = 1'b1;

        // Reset state
        tick(3);
        check("rst_data_out", {24'h0, bus.data_out}, 32'h0);
        check("rst_valid", {31'h0, bus.valid}, 32'h0);
        check("rst_frame_err", {31'h0, bus.frame_err}, 32'h0);
        check("rst_par_err", {31'h0, bus.par_err}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        rst = 1'b1;
        tick(4);

        // 0xA5 good frame
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5_busy_mid", {31'h0, bus.busy}, 32'h1);
        tick(4);
        check_events("a5");
        check("a5_data_out", {24'h0, bus.data_out}, 32'hA5);
        check("a5_busy_after", {31'h0, bus.busy}, 32'h0);

        // One-cycle glitch must be rejected as a false start
        bus.rxd = 1'b0;
        tick(1);
        bus.rxd = 1'b1;
        tick(12);
        check_events("glitch");
        check("glitch_data_out", {24'h0, bus.data_out}, 32'hA5);
        check("glitch_busy", {31'h0, bus.busy}, 32'h0);

        // Framing error with the line held low afterwards
        send_frame(8'h3C, 1'b0, 1'b0);
        tick(20);
        check("break_busy_low_line", {31'h0, bus.busy}, 32'h1);
        bus.rxd = 1'b1;
        tick(5);
        check("break_busy_released", {31'h0, bus.busy}, 32'h0);
        check_events("ferr");
        check("ferr_data_out", {24'h0, bus.data_out}, 32'hA5);
        send_frame(8'h11, 1'b1, 1'b0);
        tick(4);
        check_events("after_break");
        check("after_break_data", {24'h0, bus.data_out}, 32'h11);

`ifdef SERIAL_RX_PARITY_EN
        send_frame(8'h3C, 1'b1, 1'b0);
        tick(4);
        check_events("par_ok");
        send_frame(8'h3C, 1'b1, 1'b1);
        tick(4);
        check_events("par_bad");
        check("par_bad_data", {24'h0, bus.data_out}, 32'h3C);
`endif

        // Back-to-back frames, no idle between stop and next start
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        tick(4);
        if (got_q.size() == 2)
            check("b2b_spacing", got_q[1].cyc - got_q[0].cyc, FRAME);
        else
            check("b2b_pulses", got_q.size(), 2);
        check_events("b2b");
        check("b2b_data_out", {24'h0, bus.data_out}, 32'hFF);

        // Randomized frames, mixed gaps and stop/parity errors
        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 7) != 0);
            pf = (P == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
            send_frame(d, st, pf);
            if (!st) tick($urandom_range(0, 5));
            bus.rxd = 1'b1;
            tick($urandom_range(st ? 0 : 1, 4));
        end
        tick(6);
        check_events("random");
        check("random_data_out", {24'h0, bus.data_out}, {24'h0, last_good});

        // Reset during data bit 4 of 0x5A
        bus.rxd = 1'b0;
        tick(C);
        d = 8'h5A;
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        bus.rxd = d[4];
        tick(2);
        rst = 1'b0;
        #1;
        check("mid_rst_data_out", {24'h0, bus.data_out}, 32'h0);
        check("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
        check("mid_rst_valid", {31'h0, bus.valid}, 32'h0);
        check("mid_rst_frame_err", {31'h0, bus.frame_err}, 32'h0);
        bus.rxd   = 1'b1;
        last_good = 8'h00;
        tick(3);
        rst = 1'b1;
        tick(4);
        check_events("mid_rst");
        send_frame(8'h81, 1'b1, 1'b0);
        tick(4);
        check_events("post_rst");
        check("post_rst_data", {24'h0, bus.data_out}, 32'h81);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
